// File: rtl/err_monitor_pkg.sv
// Shared OptoHybrid error-monitor constants: default widths, the short debug
// stretch used in simulation builds, and the severity encoding for the LED
// blink-rate input.
package err_monitor_pkg;

`ifdef DEBUG
   localparam int unsigned ERRMON_HOLD_W = 3;
`else
   localparam int unsigned ERRMON_HOLD_W = 24;
`endif

   localparam int unsigned ERRMON_NSRC = 8;
   localparam int unsigned ERRMON_CNTW = 16;

   typedef enum logic [1:0] {
      RATE_QUIET = 2'd0,
      RATE_LOW   = 2'd1,
      RATE_MID   = 2'd2,
      RATE_HIGH  = 2'd3
   } rate_t;

   // Severity from the number of unmasked sources that have latched an error.
   function automatic rate_t rate_from_pop(input int unsigned p);
      if (p <= 1)
         return RATE_QUIET;
      else if (p == 2)
         return RATE_LOW;
      else if (p == 3)
         return RATE_MID;
      else
         return RATE_HIGH;
   endfunction

endpackage

// File: rtl/err_monitor_counter.sv
// Per-source saturating event counter with a sticky error bit.
module err_counter
   import err_monitor_pkg::*;
#(
   parameter int unsigned CNTW = ERRMON_CNTW
)(
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            clear_i,
   input  logic            event_i,
   output logic [CNTW-1:0] cnt_o,
   output logic            sticky_o
);

   logic [CNTW-1:0] cnt_q, cnt_d;
   logic            sticky_q, sticky_d;

   // Next state: clear dominates a coincident event; count saturates at all-ones.
   always_comb begin
      cnt_d    = cnt_q;
      sticky_d = sticky_q;
      if (clear_i) begin
         cnt_d    = '0;
         sticky_d = 1'b0;
      end else if (event_i) begin
         sticky_d = 1'b1;
         if (cnt_q != '1)
            cnt_d = cnt_q + 1'b1;
      end
   end

   // Counter and sticky registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q    <= '0;
         sticky_q <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         sticky_q <= sticky_d;
      end
   end

   assign cnt_o    = cnt_q;
   assign sticky_o = sticky_q;

endmodule

// File: rtl/err_monitor.sv
// Error monitor: synchronises asynchronous error levels, counts rising edges
// per source, stretches any event into a visible LED pulse and grades
// severity by how many unmasked sources have latched an error.
module err_monitor
   import err_monitor_pkg::*;
#(
   parameter  int unsigned NSRC   = ERRMON_NSRC,
   parameter  int unsigned CNTW   = ERRMON_CNTW,
   parameter  int unsigned HOLD_W = ERRMON_HOLD_W,
   localparam int unsigned SELW   = (NSRC > 1) ? $clog2(NSRC) : 1
)(
   input  logic              clock,
   input  logic              reset,
   input  logic [NSRC-1:0]   err_i,
   input  logic [NSRC-1:0]   mask,
   input  logic              clear,
   input  logic [SELW-1:0]   cnt_sel,
   output logic              err_o,
   output logic [1:0]        rate_o,
   output logic [NSRC-1:0]   sticky_o,
   output logic [CNTW-1:0]   cnt_o
);

   logic [NSRC-1:0]   s1_q, s2_q, s3_q;
   logic [NSRC-1:0]   event_q, event_d;
   logic [HOLD_W-1:0] timer_q, timer_d;
   logic              err_q, err_d;
   rate_t             rate_q, rate_d;
   logic [CNTW-1:0]   cnt_q, cnt_d;
   logic [CNTW-1:0]   cnt_arr [NSRC];
   logic [NSRC-1:0]   sticky_w;

   // Two-flop synchroniser plus a delayed copy for rising-edge detection.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         s1_q <= '0;
         s2_q <= '0;
         s3_q <= '0;
      end else begin
         s1_q <= err_i;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   // Event is registered so counters, sticky bits and timer all update together.
   assign event_d = s2_q & ~s3_q & ~mask;

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         event_q <= '0;
      else
         event_q <= event_d;
   end

   for (genvar g = 0; g < NSRC; g++) begin : g_src
      err_counter #(
         .CNTW (CNTW)
      ) u_cnt (
         .clk_i    (clock),
         .rst_i    (reset),
         .clear_i  (clear),
         .event_i  (event_q[g]),
         .cnt_o    (cnt_arr[g]),
         .sticky_o (sticky_w[g])
      );
   end

   // Retriggerable stretch timer; err_o tracks the next timer value so it
   // rises on the same edge the timer is loaded.
   always_comb begin
      timer_d = timer_q;
      if (clear)
         timer_d = '0;
      else if (|event_q)
         timer_d = '1;
      else if (timer_q != '0)
         timer_d = timer_q - 1'b1;
      err_d = (timer_d != '0);
   end

   // Severity from popcount of unmasked sticky bits.
   always_comb begin
      int unsigned pop;
      pop = 0;
      for (int unsigned i = 0; i < NSRC; i++) begin
         if (sticky_w[i] && !mask[i])
            pop = pop + 1;
      end
      rate_d = rate_from_pop(pop);
   end

   // Counter readback mux; out-of-range selects read as zero.
   always_comb begin
      cnt_d = '0;
      if (32'(cnt_sel) < NSRC)
         cnt_d = cnt_arr[cnt_sel];
   end

   // Registered outputs and stretch timer.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         timer_q <= '0;
         err_q   <= 1'b0;
         rate_q  <= RATE_QUIET;
         cnt_q   <= '0;
      end else begin
         timer_q <= timer_d;
         err_q   <= err_d;
         rate_q  <= rate_d;
         cnt_q   <= cnt_d;
      end
   end

   assign err_o    = err_q;
   assign rate_o   = rate_q;
   assign sticky_o = sticky_w;
   assign cnt_o    = cnt_q;

endmodule

// File: tb/tb_err_monitor.sv
// Self-checking bench for err_monitor (NSRC=8, CNTW=4, HOLD_W=3).
module tb_err_monitor;

   localparam int unsigned NSRC   = 8;
   localparam int unsigned CNTW   = 4;
   localparam int unsigned HOLD_W = 3;

   logic            clock   = 1'b0;
   logic            reset   = 1'b1;
   logic [7:0]      err_i   = '0;
   logic [7:0]      mask    = '0;
   logic            clear   = 1'b0;
   logic [2:0]      cnt_sel = '0;
   logic            err_o;
   logic [1:0]      rate_o;
   logic [7:0]      sticky_o;
   logic [3:0]      cnt_o;

   int checks = 0;
   int fails  = 0;

   typedef struct {
      int unsigned src;
      logic [3:0]  cnt;
      logic [7:0]  sticky;
   } exp_t;

   exp_t       sb_q[$];
   logic [3:0] m_cnt [8];
   logic [7:0] m_sticky;

   always #5 clock = ~clock;

   err_monitor #(
      .NSRC   (NSRC),
      .CNTW   (CNTW),
      .HOLD_W (HOLD_W)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .err_i    (err_i),
      .mask     (mask),
      .clear    (clear),
      .cnt_sel  (cnt_sel),
      .err_o    (err_o),
      .rate_o   (rate_o),
      .sticky_o (sticky_o),
      .cnt_o    (cnt_o)
   );

   task automatic tick(input int unsigned n = 1);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 8; i++) m_cnt[i] = '0;
      m_sticky = '0;
   endtask

   // Reference model of one accepted event; pushes the expected readback.
   task automatic model_event(input int unsigned src);
      exp_t e;
      if (!mask[src]) begin
         if (m_cnt[src] != 4'hF) m_cnt[src] = m_cnt[src] + 4'd1;
         m_sticky[src] = 1'b1;
         e.src    = src;
         e.cnt    = m_cnt[src];
         e.sticky = m_sticky;
         sb_q.push_back(e);
      end
   endtask

   // One-cycle pulse; returns once cnt_o reflects the update.
   task automatic pulse(input int unsigned src);
      err_i[src] = 1'b1;
      tick();
      err_i[src] = 1'b0;
      tick(4);
      model_event(src);
   endtask

   task automatic do_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      model_clear();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      model_clear();
      tick(2);
      checks++;
      if (err_o !== 1'b0 || rate_o !== 2'd0 || sticky_o !== 8'h00 || cnt_o !== 4'h0) begin
         fails++;
         $display("FAIL reset_state: err=%b rate=%0d sticky=%h cnt=%0d, required 0 0 00 0",
                  err_o, rate_o, sticky_o, cnt_o);
      end
      reset = 1'b0;
      tick(2);
   endtask

   task automatic test_single_pulse();
      exp_t       e;
      logic [9:0] seen;
      cnt_sel = 3'd2;
      err_i[2] = 1'b1;
      tick();                     // sampling edge k
      err_i[2] = 1'b0;
      tick(2);                    // edge k+2
      checks++;
      if (err_o !== 1'b0) begin
         fails++;
         $display("FAIL stretch_early: err_o=%b required 0", err_o);
      end
      for (int i = 0; i < 10; i++) begin
         tick();                  // edges k+3 .. k+12
         seen[i] = err_o;
      end
      checks++;
      if (seen !== 10'b0001111111) begin
         fails++;
         $display("FAIL stretch_len: err_o samples=%b required %b", seen, 10'b0001111111);
      end
      model_event(2);
      e = sb_q.pop_front();
      checks++;
      if (cnt_o !== e.cnt || sticky_o !== e.sticky || rate_o !== 2'd0) begin
         fails++;
         $display("FAIL single_pulse: cnt=%0d sticky=%h rate=%0d, required %0d %h 0",
                  cnt_o, sticky_o, rate_o, e.cnt, e.sticky);
      end
   endtask

   task automatic test_level_hold();
      exp_t e;
      cnt_sel = 3'd0;
      err_i[0] = 1'b1;
      tick(100);
      model_event(0);
      for (int i = 0; i < 6; i++) begin
         if (i > 0) pulse(0);
         else begin
            err_i[0] = 1'b0;
            tick(3);
         end
         e = sb_q.pop_front();
         checks++;
         if (cnt_o !== e.cnt) begin
            fails++;
            $display("FAIL level_count[%0d]: cnt_o=%0d required %0d", i, cnt_o, e.cnt);
         end
      end
   endtask

   task automatic test_saturate();
      exp_t e;
      cnt_sel = 3'd5;
      for (int i = 0; i < 20; i++) begin
         pulse(5);
         e = sb_q.pop_front();
         checks++;
         if (cnt_o !== e.cnt || sticky_o[5] !== 1'b1) begin
            fails++;
            $display("FAIL saturate[%0d]: cnt_o=%0d sticky5=%b required %0d 1",
                     i, cnt_o, sticky_o[5], e.cnt);
         end
      end
      checks++;
      if (cnt_o !== 4'd15) begin
         fails++;
         $display("FAIL saturate_final: cnt_o=%0d required 15", cnt_o);
      end
   endtask

   task automatic test_rate_mask();
      exp_t       e;
      int unsigned srcs [4] = '{0, 1, 3, 6};
      logic [7:0] masks [4] = '{8'h00, 8'h40, 8'h48, 8'h49};
      logic [1:0] rates [4] = '{2'd3, 2'd2, 2'd1, 2'd0};
      do_clear();
      for (int i = 0; i < 4; i++) begin
         cnt_sel = 3'(srcs[i]);
         pulse(srcs[i]);
         e = sb_q.pop_front();
         checks++;
         if (cnt_o !== e.cnt || sticky_o !== e.sticky) begin
            fails++;
            $display("FAIL rate_setup[%0d]: cnt=%0d sticky=%h required %0d %h",
                     i, cnt_o, sticky_o, e.cnt, e.sticky);
         end
      end
      for (int i = 0; i < 4; i++) begin
         mask = masks[i];
         tick(2);
         checks++;
         if (rate_o !== rates[i] || sticky_o !== 8'h4B) begin
            fails++;
            $display("FAIL rate_mask[%h]: rate=%0d sticky=%h required %0d 4b",
                     mask, rate_o, sticky_o, rates[i]);
         end
      end
      cnt_sel = 3'd3;
      tick();
      checks++;
      if (cnt_o !== m_cnt[3]) begin
         fails++;
         $display("FAIL masked_cnt_kept: cnt_o=%0d required %0d", cnt_o, m_cnt[3]);
      end
      mask = '0;
      tick();
   endtask

   task automatic test_clear_collision();
      cnt_sel = 3'd4;
      err_i[4] = 1'b1;
      tick();                     // edge k
      err_i[4] = 1'b0;
      tick(2);                    // edge k+2: event registered
      clear = 1'b1;
      tick();                     // edge k+3: clear meets the event
      clear = 1'b0;
      model_clear();
      checks++;
      if (sticky_o !== 8'h00 || err_o !== 1'b0) begin
         fails++;
         $display("FAIL clear_wins: sticky=%h err_o=%b required 00 0", sticky_o, err_o);
      end
      tick(2);
      checks++;
      if (err_o !== 1'b0 || rate_o !== 2'd0) begin
         fails++;
         $display("FAIL clear_after: err_o=%b rate=%0d required 0 0", err_o, rate_o);
      end
      for (int i = 0; i < 8; i++) begin
         cnt_sel = 3'(i);
         tick();
         checks++;
         if (cnt_o !== m_cnt[i]) begin
            fails++;
            $display("FAIL clear_cnt[%0d]: cnt_o=%0d required %0d", i, cnt_o, m_cnt[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      err_i = 8'hA5;
      tick();
      err_i = '0;
      tick(4);
      for (int i = 0; i < 8; i++) begin
         logic [7:0] pat;
         pat = 8'hA5;
         if (pat[i]) model_event(i);
      end
      while (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         cnt_sel = 3'(e.src);
         tick();
         checks++;
         if (cnt_o !== e.cnt || sticky_o !== 8'hA5) begin
            fails++;
            $display("FAIL simultaneous[%0d]: cnt=%0d sticky=%h required %0d a5",
                     e.src, cnt_o, sticky_o, e.cnt);
         end
      end
   endtask

   task automatic test_reset_mid_stretch();
      exp_t        e;
      int unsigned srcs [12] = '{2, 4, 6, 1, 1, 1, 1, 1, 1, 1, 1, 1};
      do_clear();
      for (int i = 0; i < 12; i++) begin
         cnt_sel = 3'(srcs[i]);
         pulse(srcs[i]);
         e = sb_q.pop_front();
         checks++;
         if (cnt_o !== e.cnt) begin
            fails++;
            $display("FAIL pre_reset_cnt[%0d]: cnt_o=%0d required %0d", i, cnt_o, e.cnt);
         end
      end
      checks++;
      if (err_o !== 1'b1 || rate_o !== 2'd3 || cnt_o !== 4'd9) begin
         fails++;
         $display("FAIL pre_reset_state: err=%b rate=%0d cnt=%0d required 1 3 9",
                  err_o, rate_o, cnt_o);
      end
      err_i[3] = 1'b1;
      #3;
      reset = 1'b1;
      #1;
      checks++;
      if (err_o !== 1'b0 || rate_o !== 2'd0 || cnt_o !== 4'd0 || sticky_o !== 8'h00) begin
         fails++;
         $display("FAIL async_reset: err=%b rate=%0d cnt=%0d sticky=%h required 0 0 0 00",
                  err_o, rate_o, cnt_o, sticky_o);
      end
      model_clear();
      cnt_sel = 3'd3;
      tick();
      reset = 1'b0;
      tick(5);
      model_event(3);
      e = sb_q.pop_front();
      checks++;
      if (cnt_o !== e.cnt || sticky_o !== e.sticky) begin
         fails++;
         $display("FAIL high_at_release: cnt=%0d sticky=%h required %0d %h",
                  cnt_o, sticky_o, e.cnt, e.sticky);
      end
      tick(10);
      err_i[3] = 1'b0;
      for (int i = 0; i < 8; i++) begin
         cnt_sel = 3'(i);
         tick();
         checks++;
         if (cnt_o !== m_cnt[i]) begin
            fails++;
            $display("FAIL post_reset_cnt[%0d]: cnt_o=%0d required %0d", i, cnt_o, m_cnt[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_pulse();
      test_level_hold();
      test_saturate();
      test_rate_mask();
      test_clear_collision();
      test_back_to_back();
      test_reset_mid_stretch();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
